// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the AXI read-channel arbiter: FSM state encoding,
// constant AR field values and the default transaction IDs of the two ports.
package axi_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2
  } state_e;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // Also used by the write-channel logic in mmu_top.
  localparam logic [3:0] ID_INST_DEFAULT = 4'd0;
  localparam logic [3:0] ID_DATA_DEFAULT = 4'd1;

  // Encoding of the grant / last-grant bits.
  localparam logic GRANT_INST = 1'b0;
  localparam logic GRANT_DATA = 1'b1;

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// AXI read-address and read-data channels.
//   master : drives AR payload/arvalid and rready (the arbiter)
//   slave  : drives arready and the R payload/rvalid (interconnect or model)
interface axi_rd_arbiter_if;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// Two-requester round-robin picker (combinational).
//   req[0] = instruction port, req[1] = data port
//   last_grant : port granted most recently (0 = inst, 1 = data)
//   grant      : winner (0 = inst, 1 = data); meaningless when req == 0
module rr_arb2
  import axi_rd_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant
);

  always_comb begin
    grant = GRANT_INST;
    unique case (req)
      2'b01:   grant = GRANT_INST;
      2'b10:   grant = GRANT_DATA;
      // Tie goes to whoever did not win last time.
      2'b11:   grant = ~last_grant;
      default: grant = GRANT_INST;
    endcase
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read channel between the instruction-cache and data-cache
// refill ports. One burst outstanding at a time, round-robin on ties.
//   clk, rst              : clock, synchronous active-high reset
//   inst_req/addr/len     : instruction port burst request (len = beats - 1)
//   inst_rdata/rvalid/rlast/err : beats steered back to the instruction port
//   data_*                : same for the data port
//   axi                   : AXI AR/R channel, master side
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter logic [3:0] ID_INST = ID_INST_DEFAULT,
  parameter logic [3:0] ID_DATA = ID_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic [7:0]  inst_len,
  output logic [31:0] inst_rdata,
  output logic        inst_rvalid,
  output logic        inst_rlast,
  output logic        inst_err,

  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic [7:0]  data_len,
  output logic [31:0] data_rdata,
  output logic        data_rvalid,
  output logic        data_rlast,
  output logic        data_err,

  axi_rd_arbiter_if.master axi
);

  state_e      state_q;
  logic        grant_q;
  logic        last_grant_q;
  logic        arb_grant;
  logic [31:0] araddr_q;
  logic [7:0]  arlen_q;
  logic [3:0]  arid_q;
  logic        arvalid_q;
  logic        rready_q;

  rr_arb2 u_rr_arb2 (
    .req        ({data_req, inst_req}),
    .last_grant (last_grant_q),
    .grant      (arb_grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_q      <= GRANT_INST;
      last_grant_q <= GRANT_DATA;  // inst wins the first tie
      araddr_q     <= '0;
      arlen_q      <= '0;
      arid_q       <= ID_INST;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (inst_req || data_req) begin
            grant_q   <= arb_grant;
            araddr_q  <= (arb_grant == GRANT_DATA) ? data_addr : inst_addr;
            arlen_q   <= (arb_grant == GRANT_DATA) ? data_len  : inst_len;
            arid_q    <= (arb_grant == GRANT_DATA) ? ID_DATA   : ID_INST;
            arvalid_q <= 1'b1;
            state_q   <= StAddr;
          end
        end
        StAddr: begin
          if (arvalid_q && axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= StData;
          end
        end
        StData: begin
          if (axi.rvalid && axi.rlast) begin
            rready_q     <= 1'b0;
            last_grant_q <= grant_q;
            state_q      <= StIdle;
          end
        end
        default: begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

  assign axi.arid    = arid_q;
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = arlen_q;
  assign axi.arsize  = AXI_SIZE_4B;
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'b0000;
  assign axi.arprot  = 3'b000;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

  // rready_q is high exactly in DATA, so it qualifies beats for the ports.
  logic beat;
  logic beat_err;

  always_comb begin
    beat        = rready_q & axi.rvalid;
    beat_err    = |axi.rresp;
    inst_rdata  = axi.rdata;
    data_rdata  = axi.rdata;
    inst_rvalid = beat & (grant_q == GRANT_INST);
    data_rvalid = beat & (grant_q == GRANT_DATA);
    inst_rlast  = inst_rvalid & axi.rlast;
    data_rlast  = data_rvalid & axi.rlast;
    inst_err    = inst_rvalid & beat_err;
    data_err    = data_rvalid & beat_err;
  end

  // Single outstanding transaction, so the returned ID carries no information.
  logic unused_rid;
  assign unused_rid = ^axi.rid;

endmodule
